// File: rtl/hyper_frdram_sched.sv
// Round-robin scheduler that feeds four per-section read-block requests to the single DRAM-to-LSAB mover.
// Optional watchdog on the mover start: define HYPER_FRDRAM_SCHED_WDOG_EN.
module hyper_frdram_sched #(
  parameter int WDOG_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [35:0] REQ_ADDR,
  input  logic [23:0] REQ_COUNT,
  input  logic [7:0]  REQ_DRAM_SEL,
  input  logic [3:0]  LSAB_FULL,
  output logic [3:0]  GRANT_ACK,
  output logic [3:0]  DONE,
  output logic [5:0]  DONE_COUNT,
  output logic        DONE_ABRUPT,
  output logic        DONE_DEVERR,
  output logic        BUSY,
  output logic [8:0]  MV_START_ADDRESS,
  output logic [5:0]  MV_COUNT_REQ,
  output logic [1:0]  MV_SECTION,
  output logic [1:0]  MV_DRAM_SEL,
  output logic        MV_ISSUE,
  input  logic        MV_WORKING,
  input  logic [5:0]  MV_COUNT_SENT,
  input  logic        MV_ABRUPT_STOP,
  input  logic        MV_DEVICE_ERROR,
`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
  output logic        WDOG_ERR,
`endif
  output logic [2:0]  STATE_DBG
);

  // Handshakes: REQ[n] is a level held by the requester until the one-cycle GRANT_ACK[n];
  // MV_ISSUE is a one-cycle command, MV_WORKING high means the mover owns the transfer,
  // and DONE[n] is a one-cycle report whose DONE_* fields are valid only in that cycle.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_DRAIN      = 3'd4,
    S_REPORT     = 3'd5
  } state_t;

  state_t     state;
  logic [1:0] rr_ptr;
  logic       drain_cnt;
  logic [3:0] eligible;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
  logic [4:0] wdog_cnt;
`endif

  assign eligible  = REQ & ~LSAB_FULL;
  assign BUSY      = (state != S_IDLE);
  assign STATE_DBG = state;

  // First eligible section after the last one served, wrapping mod 4.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && eligible[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state            <= S_IDLE;
      rr_ptr           <= 2'd3;
      drain_cnt        <= 1'b0;
      GRANT_ACK        <= '0;
      DONE             <= '0;
      DONE_COUNT       <= '0;
      DONE_ABRUPT      <= 1'b0;
      DONE_DEVERR      <= 1'b0;
      MV_START_ADDRESS <= '0;
      MV_COUNT_REQ     <= '0;
      MV_SECTION       <= '0;
      MV_DRAM_SEL      <= '0;
      MV_ISSUE         <= 1'b0;
`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
      wdog_cnt         <= '0;
      WDOG_ERR         <= 1'b0;
`endif
    end else begin
      GRANT_ACK   <= '0;
      MV_ISSUE    <= 1'b0;
      DONE        <= '0;
      DONE_COUNT  <= '0;
      DONE_ABRUPT <= 1'b0;
      DONE_DEVERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            MV_START_ADDRESS <= REQ_ADDR[9*int'(pick) +: 9];
            MV_COUNT_REQ     <= REQ_COUNT[6*int'(pick) +: 6];
            MV_DRAM_SEL      <= REQ_DRAM_SEL[2*int'(pick) +: 2];
            MV_SECTION       <= pick;
            GRANT_ACK        <= 4'b0001 << pick;
            rr_ptr           <= pick;
            MV_ISSUE         <= 1'b1;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
          wdog_cnt <= '0;
`endif
          state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (MV_WORKING) begin
            state <= S_WAIT_DONE;
          end
`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
          else if (wdog_cnt == 5'(WDOG_CYCLES - 1)) begin
            // Mover never started: report as an abrupt stop with nothing moved.
            state       <= S_REPORT;
            DONE        <= 4'b0001 << MV_SECTION;
            DONE_ABRUPT <= 1'b1;
            WDOG_ERR    <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 5'd1;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (!MV_WORKING) begin
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Two fixed cycles so the trailing LSAB write lands in MV_COUNT_SENT.
          if (drain_cnt) begin
            state       <= S_REPORT;
            DONE        <= 4'b0001 << MV_SECTION;
            DONE_COUNT  <= MV_COUNT_SENT;
            DONE_ABRUPT <= MV_ABRUPT_STOP;
            DONE_DEVERR <= MV_DEVICE_ERROR;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_frdram_sched.sv
// Directed bench for hyper_frdram_sched: stimulus pushes expected issues/reports, a monitor pops and compares.
module tb_hyper_frdram_sched;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [35:0] REQ_ADDR;
  logic [23:0] REQ_COUNT;
  logic [7:0]  REQ_DRAM_SEL;
  logic [3:0]  LSAB_FULL;
  logic [3:0]  GRANT_ACK;
  logic [3:0]  DONE;
  logic [5:0]  DONE_COUNT;
  logic        DONE_ABRUPT;
  logic        DONE_DEVERR;
  logic        BUSY;
  logic [8:0]  MV_START_ADDRESS;
  logic [5:0]  MV_COUNT_REQ;
  logic [1:0]  MV_SECTION;
  logic [1:0]  MV_DRAM_SEL;
  logic        MV_ISSUE;
  logic        MV_WORKING;
  logic [5:0]  MV_COUNT_SENT;
  logic        MV_ABRUPT_STOP;
  logic        MV_DEVICE_ERROR;
  logic [2:0]  STATE_DBG;
`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
  logic        WDOG_ERR;
`endif

  hyper_frdram_sched #(.WDOG_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_COUNT(REQ_COUNT),
    .REQ_DRAM_SEL(REQ_DRAM_SEL), .LSAB_FULL(LSAB_FULL), .GRANT_ACK(GRANT_ACK), .DONE(DONE),
    .DONE_COUNT(DONE_COUNT), .DONE_ABRUPT(DONE_ABRUPT), .DONE_DEVERR(DONE_DEVERR), .BUSY(BUSY),
    .MV_START_ADDRESS(MV_START_ADDRESS), .MV_COUNT_REQ(MV_COUNT_REQ), .MV_SECTION(MV_SECTION),
    .MV_DRAM_SEL(MV_DRAM_SEL), .MV_ISSUE(MV_ISSUE), .MV_WORKING(MV_WORKING),
    .MV_COUNT_SENT(MV_COUNT_SENT), .MV_ABRUPT_STOP(MV_ABRUPT_STOP), .MV_DEVICE_ERROR(MV_DEVICE_ERROR),
`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
    .WDOG_ERR(WDOG_ERR),
`endif
    .STATE_DBG(STATE_DBG)
  );

  // Per-section constants: addr, count, dram_sel.
  localparam logic [8:0] A0 = 9'h010, A1 = 9'h1A5, A2 = 9'h0FF, A3 = 9'h120;
  localparam logic [5:0] C0 = 6'd8,   C1 = 6'd33,  C2 = 6'd63,  C3 = 6'd0;
  localparam logic [1:0] S0 = 2'd1,   S1 = 2'd2,   S2 = 2'd3,   S3 = 2'd0;

  int checks = 0;
  int errors = 0;

  // issue entry: {section, addr, count, sel}; done entry: {done_vec, count, abrupt, deverr}
  logic [18:0] issue_q[$];
  logic [11:0] done_q[$];
  logic [18:0] mon_ie;
  logic [11:0] mon_de;
  bit          outstanding;

  // Mover model knobs
  int   m_start_dly = 2;
  int   m_len       = 4;
  bit   m_abrupt    = 0;
  bit   m_deverr    = 0;
  bit   m_never     = 0;
  logic [5:0] m_count = 6'd0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] iss(input int s);
    case (s)
      0: iss = {2'd0, A0, C0, S0};
      1: iss = {2'd1, A1, C1, S1};
      2: iss = {2'd2, A2, C2, S2};
      default: iss = {2'd3, A3, C3, S3};
    endcase
  endfunction

  function automatic logic [11:0] dn(input int s, input logic [5:0] cnt, input logic ab, input logic de);
    dn = {4'b0001 << s, cnt, ab, de};
  endfunction

  // Mover model: reacts to MV_ISSUE, drives WORKING and the result fields.
  initial begin
    logic [5:0] req_cnt;
    MV_WORKING = 0; MV_COUNT_SENT = '0; MV_ABRUPT_STOP = 0; MV_DEVICE_ERROR = 0;
    forever begin
      @(negedge CLK);
      if (RST && MV_ISSUE && !m_never) begin
        req_cnt = MV_COUNT_REQ;
        MV_COUNT_SENT = '0; MV_ABRUPT_STOP = 0; MV_DEVICE_ERROR = 0;
        repeat (m_start_dly) @(negedge CLK);
        MV_WORKING = 1;
        for (int i = 0; i < m_len && RST; i++) @(negedge CLK);
        if (RST) begin
          MV_COUNT_SENT   = m_abrupt ? m_count : req_cnt;
          MV_ABRUPT_STOP  = m_abrupt;
          MV_DEVICE_ERROR = m_deverr;
        end else begin
          MV_COUNT_SENT = '0;
        end
        MV_WORKING = 0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (!RST) begin
      outstanding = 0;
    end else begin
      if (MV_ISSUE) begin
        chk("issue_without_done", outstanding, 0);
        if (issue_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue actual=section%0d expected=none", MV_SECTION);
        end else begin
          mon_ie = issue_q.pop_front();
          chk("issue_fields", {MV_SECTION, MV_START_ADDRESS, MV_COUNT_REQ, MV_DRAM_SEL}, mon_ie);
          chk("grant_ack", GRANT_ACK, 4'b0001 << mon_ie[18:17]);
        end
        outstanding = 1;
      end
      if (|DONE) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=%0h expected=none", DONE);
        end else begin
          mon_de = done_q.pop_front();
          chk("done_fields", {DONE, DONE_COUNT, DONE_ABRUPT, DONE_DEVERR}, mon_de);
        end
        outstanding = 0;
      end
    end
  end

  task automatic wait_ack(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 500) begin
      @(negedge CLK);
      cyc++;
      if (|GRANT_ACK) got++;
    end
    chk("ack_wait", got, n);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while ((BUSY || done_q.size() != 0) && cyc < 300);
    chk("idle_wait_in_budget", cyc < 300, 1);
  endtask

  task automatic apply_reset();
    RST = 0;
    repeat (3) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
  endtask

  initial begin
    int cyc;
    RST = 0; REQ = '0; LSAB_FULL = '0;
    REQ_ADDR     = {A3, A2, A1, A0};
    REQ_COUNT    = {C3, C2, C1, C0};
    REQ_DRAM_SEL = {S3, S2, S1, S0};
    #2;
    chk("reset_outputs", {GRANT_ACK, DONE, DONE_COUNT, DONE_ABRUPT, DONE_DEVERR, BUSY,
                          MV_START_ADDRESS, MV_COUNT_REQ, MV_SECTION, MV_DRAM_SEL, MV_ISSUE}, 0);
    chk("reset_state", STATE_DBG, 0);
    repeat (2) @(negedge CLK);
    RST = 1;
    @(negedge CLK);

    // Single request on section 0
    issue_q.push_back(iss(0));
    done_q.push_back(dn(0, C0, 0, 0));
    REQ = 4'b0001;
    @(negedge CLK);
    chk("grant_latency", GRANT_ACK, 4'b0001);
    REQ = '0;
    wait_idle();

    // Fairness: all sections requesting from a fresh reset
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      issue_q.push_back(iss(k % 4));
      done_q.push_back(dn(k % 4, (k % 4 == 0) ? C0 : (k % 4 == 1) ? C1 : (k % 4 == 2) ? C2 : C3, 0, 0));
    end
    REQ = 4'b1111;
    wait_ack(6);
    REQ = '0;
    wait_idle();

    // Full mask: section 0 blocked, section 1 (just served) re-granted
    issue_q.push_back(iss(1));
    done_q.push_back(dn(1, C1, 0, 0));
    LSAB_FULL = 4'b0001;
    REQ = 4'b0011;
    wait_ack(1);
    REQ = 4'b0001;
    wait_idle();
    repeat (5) @(negedge CLK);
    chk("full_section_held_off", BUSY, 0);
    issue_q.push_back(iss(0));
    done_q.push_back(dn(0, C0, 0, 0));
    LSAB_FULL = '0;
    wait_ack(1);
    REQ = '0;
    wait_idle();

    // Abrupt stop at 5 words on section 2
    m_abrupt = 1; m_count = 6'd5;
    issue_q.push_back(iss(2));
    done_q.push_back(dn(2, 6'd5, 1, 0));
    REQ = 4'b0100;
    wait_ack(1);
    REQ = '0;
    wait_idle();
    chk("idle_after_abrupt", STATE_DBG, 0);
    m_abrupt = 0;

    // Device error, zero word count on section 3
    m_deverr = 1;
    issue_q.push_back(iss(3));
    done_q.push_back(dn(3, 6'd0, 0, 1));
    REQ = 4'b1000;
    wait_ack(1);
    REQ = '0;
    wait_idle();
    m_deverr = 0;

    // Reset during WAIT_DONE
    m_len = 30;
    issue_q.push_back(iss(1));
    REQ = 4'b0010;
    wait_ack(1);
    REQ = '0;
    cyc = 0;
    while (STATE_DBG != 3'd3 && cyc < 50) begin @(negedge CLK); cyc++; end
    chk("reached_wait_done", STATE_DBG, 3);
    #2 RST = 0;
    #1;
    chk("async_reset_outputs", {GRANT_ACK, DONE, DONE_COUNT, DONE_ABRUPT, DONE_DEVERR, BUSY,
                                MV_START_ADDRESS, MV_COUNT_REQ, MV_SECTION, MV_DRAM_SEL, MV_ISSUE}, 0);
    repeat (3) @(negedge CLK);
    RST = 1;
    m_len = 4;
    @(negedge CLK);
    issue_q.push_back(iss(2));
    done_q.push_back(dn(2, C2, 0, 0));
    REQ = 4'b0100;
    @(negedge CLK);
    chk("first_grant_after_reset", GRANT_ACK, 4'b0100);
    REQ = '0;
    wait_idle();

`ifdef HYPER_FRDRAM_SCHED_WDOG_EN
    // Watchdog: mover never starts
    chk("wdog_clear_before", WDOG_ERR, 0);
    m_never = 1;
    issue_q.push_back(iss(0));
    done_q.push_back(dn(0, 6'd0, 1, 0));
    REQ = 4'b0001;
    wait_ack(1);
    REQ = '0;
    @(negedge CLK);
    chk("wdog_in_wait_start", STATE_DBG, 2);
    cyc = 0;
    while (DONE == 4'b0000 && cyc < 100) begin @(negedge CLK); cyc++; end
    chk("wdog_latency", cyc, 16);
    wait_idle();
    m_never = 0;
    chk("wdog_err_set", WDOG_ERR, 1);
    issue_q.push_back(iss(1));
    done_q.push_back(dn(1, C1, 0, 0));
    REQ = 4'b0010;
    wait_ack(1);
    REQ = '0;
    wait_idle();
    chk("wdog_err_sticky", WDOG_ERR, 1);
`endif

    repeat (3) @(negedge CLK);
    chk("issue_q_drained", issue_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyper_frdram_sched.md
Name: hyper_frdram_sched

Overview:
- Arbitrates four per-section read-block requesters (one per LSAB section 0..3) onto the single DRAM-to-LSAB block mover.
- Round-robin grant; LSAB sections currently full are skipped.
- Sequences the mover: one-cycle ISSUE pulse, then waits for WORKING to rise and fall, then drains.
- Reports words moved plus stop/error status back to the requester that issued the move.

Parameters:
- WDOG_CYCLES, 16: cycles allowed between MV_ISSUE and MV_WORKING rising (watchdog feature only).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- REQ  in  4  per-section request level; held until matching GRANT_ACK
- REQ_ADDR  in  36  section n start address at bits [9n+8:9n]
- REQ_COUNT  in  24  section n word count at bits [6n+5:6n]
- REQ_DRAM_SEL  in  8  section n DRAM select at bits [2n+1:2n]
- LSAB_FULL  in  4  per-section LSAB full flag
- GRANT_ACK  out  4  one-cycle pulse: request n accepted, REQ may drop
- DONE  out  4  one-cycle pulse: move for section n finished
- DONE_COUNT  out  6  words written; valid with DONE
- DONE_ABRUPT  out  1  mover stopped early; valid with DONE
- DONE_DEVERR  out  1  device error; valid with DONE
- BUSY  out  1  state not IDLE
- MV_START_ADDRESS  out  9  to mover
- MV_COUNT_REQ  out  6  to mover
- MV_SECTION  out  2  to mover
- MV_DRAM_SEL  out  2  to mover
- MV_ISSUE  out  1  to mover, one-cycle pulse
- MV_WORKING  in  1  from mover
- MV_COUNT_SENT  in  6  from mover
- MV_ABRUPT_STOP  in  1  from mover
- MV_DEVICE_ERROR  in  1  from mover
- WDOG_ERR  out  1  present only with the optional feature

Behaviour:
- Reset (RST low, asynchronous):
  - State IDLE; rr_ptr = 3, so section 0 has first priority.
  - All outputs 0; in-flight move is abandoned. The mover shares RST.
- Eligibility: eligible[n] = REQ[n] & ~LSAB_FULL[n].
- IDLE:
  - If any section is eligible, pick the first eligible section searching rr_ptr+1, rr_ptr+2, ... (mod 4).
  - Latch that section's addr/count/dram_sel into the MV_* registers and set MV_SECTION = n.
  - Pulse GRANT_ACK[n], set rr_ptr = n, go to ISSUE.
- ISSUE (1 cycle): MV_ISSUE = 1, reset the watchdog counter, go to WAIT_START.
- WAIT_START: stay until MV_WORKING = 1, then go to WAIT_DONE. MV_ISSUE is held 0.
- WAIT_DONE: stay until MV_WORKING = 0, then go to DRAIN.
- DRAIN (2 cycles, fixed): lets the trailing LSAB write finish incrementing MV_COUNT_SENT. Then go to REPORT.
- REPORT (1 cycle):
  - DONE[MV_SECTION] = 1.
  - DONE_COUNT = MV_COUNT_SENT; DONE_ABRUPT = MV_ABRUPT_STOP; DONE_DEVERR = MV_DEVICE_ERROR.
  - Go to IDLE. The DONE_* fields are zero in every other cycle.
- Throughput: one move in flight at a time. Minimum IDLE-to-IDLE period is 5 cycles plus the mover's WORKING time.
- MV_* address/count/section/dram_sel registers are stable from ISSUE through REPORT.
- Boundaries:
  - REQ dropped before GRANT_ACK: treated as withdrawn, nothing is issued.
  - LSAB_FULL rising after grant: ignored by the scheduler; the mover's own abrupt stop handles it.
  - All requesters eligible and constant: grant order is 0,1,2,3,0,...
  - Only the just-served section eligible: it is re-granted immediately.
  - REQ_COUNT = 0: passed through unchanged; the mover defines the result.
  - Abrupt stop or device error: reported only. No automatic retry; the requester re-requests the residual itself.
  - MV_WORKING already 1 in IDLE: not an error. The IDLE grant decision ignores it.

Optional Feature:
- Macro HYPER_FRDRAM_SCHED_WDOG_EN.
- Defined:
  - A 5-bit counter runs in WAIT_START.
  - On reaching WDOG_CYCLES, the FSM goes to REPORT with DONE_COUNT = 0, DONE_ABRUPT = 1, DONE_DEVERR = 0.
  - WDOG_ERR is set sticky; only RST clears it.
- Undefined: the WDOG_ERR port and counter are absent, and WAIT_START waits indefinitely.

Test Plan:
- Single request: REQ = 0001, addr 0x010, count 8, sel 01, mover model returns COUNT_SENT = 8 -> GRANT_ACK[0] on the cycle after REQ; MV_ISSUE pulses once with addr 0x010, count 8, section 0, sel 01; DONE[0] with DONE_COUNT = 8 and ABRUPT = DEVERR = 0.
- Fairness: REQ = 1111 held, re-asserted after each ACK -> grant order 0,1,2,3,0,1; never two MV_ISSUE pulses without an intervening DONE.
- Full mask: REQ = 0011, LSAB_FULL = 0001 -> section 1 granted; section 0 granted only after LSAB_FULL[0] = 0.
- Abrupt stop: mover model stops at COUNT_SENT = 5 with ABRUPT_STOP = 1 -> DONE with DONE_COUNT = 5, DONE_ABRUPT = 1, and the FSM returns to IDLE.
- Reset mid-move: RST low during WAIT_DONE -> all outputs 0 asynchronously; after release, REQ = 0100 is granted as the first transaction.
- Watchdog (macro on, WDOG_CYCLES = 16): mover never raises WORKING -> DONE 16 cycles after WAIT_START entry with DONE_ABRUPT = 1 and WDOG_ERR = 1 sticky.
